// File: rtl/trace_emitter_pkg.sv
// Shared encodings for the trace emitter: FSM states, line lengths, ASCII codes, checker verdicts.
package trace_emitter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam int REG_LINE_LEN = 32;
    localparam int MEM_LINE_LEN = 38;

    localparam logic [7:0] ASCII_SP     = 8'h20;
    localparam logic [7:0] ASCII_CARET  = 8'h5e;
    localparam logic [7:0] ASCII_AT     = 8'h40;
    localparam logic [7:0] ASCII_COLON  = 8'h3a;
    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2a;
    localparam logic [7:0] ASCII_LT     = 8'h3c;
    localparam logic [7:0] ASCII_EQ     = 8'h3d;
    localparam logic [7:0] ASCII_HASH   = 8'h23;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_A_LC   = 8'h61;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    // k = 0 selects the most significant nibble
    function automatic logic [3:0] word_nibble(input logic [31:0] w, input logic [2:0] k);
        return w[{3'd7 - k, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/trace_hex_char.sv
// Nibble to ASCII: lowercase hex digit, or raw nibble+'0' when bcd is set (no range correction).
// Purely combinational.
module trace_hex_char
    import trace_emitter_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       bcd,
    output logic [7:0] ascii
);

    always_comb begin
        if (bcd || nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_A_LC + {4'h0, nibble - 4'd10};
        end
    end

endmodule

// File: rtl/trace_emitter.sv
// Serialises register/memory write traces into ASCII lines, one char per cycle, round-robin between channels.
// First char appears the cycle after grant; requests hold until their one-cycle ack and wait while a line is emitted.
module trace_emitter
    import trace_emitter_pkg::*;
#(
    parameter int ERR_W    = 8,
    parameter int CHECK_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_req,
    input  logic [15:0]      reg_time,
    input  logic [31:0]      reg_pc,
    input  logic [4:0]       reg_num,
    input  logic [31:0]      reg_data,
    output logic             reg_ack,
    input  logic             mem_req,
    input  logic [15:0]      mem_time,
    input  logic [31:0]      mem_pc,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data,
    output logic             mem_ack,
    output logic [7:0]       char,
    input  logic [1:0]       format_type,
    output logic             busy,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt
);

    state_t      state;
    logic [5:0]  idx;
    logic        rr_mem_first;
    logic        lat_mem;
    logic [15:0] lat_time;
    logic [31:0] lat_pc;
    logic [31:0] lat_f2;
    logic [31:0] lat_data;

    logic        grant_reg;
    logic        grant_mem;
    logic [5:0]  last_idx;
    logic [1:0]  exp_fmt;
    logic [5:0]  pos;
    logic [5:0]  rpos;
    logic        lit_sel;
    logic [7:0]  lit_char;
    logic [3:0]  nib;
    logic        nib_bcd;
    logic [7:0]  hex_ascii;
    logic [7:0]  nxt_char;
    logic [4:0]  num;
    logic [3:0]  num_tens;
    logic [3:0]  num_ones;

    assign grant_reg = reg_req && (!mem_req || !rr_mem_first);
    assign grant_mem = mem_req && !grant_reg;
    assign last_idx  = lat_mem ? 6'(MEM_LINE_LEN - 1) : 6'(REG_LINE_LEN - 1);
    assign exp_fmt   = lat_mem ? FMT_MEM : FMT_REG;

    always_comb begin
        num      = lat_f2[4:0];
        num_tens = 4'd0;
        num_ones = 4'(num);
        if (num >= 5'd30) begin
            num_tens = 4'd3;
            num_ones = 4'(num - 5'd30);
        end else if (num >= 5'd20) begin
            num_tens = 4'd2;
            num_ones = 4'(num - 5'd20);
        end else if (num >= 5'd10) begin
            num_tens = 4'd1;
            num_ones = 4'(num - 5'd10);
        end
    end

    // Mem lines insert 8 address digits where reg lines carry "nn"; past that the
    // two layouts coincide after a fixed shift of 6 positions.
    always_comb begin
        pos      = idx + 6'd1;
        rpos     = (lat_mem && pos >= 6'd25) ? pos - 6'd6 : pos;
        lit_sel  = 1'b1;
        lit_char = ASCII_SP;
        nib      = 4'd0;
        nib_bcd  = 1'b0;
        if (lat_mem && pos >= 6'd17 && pos <= 6'd24) begin
            lit_sel = 1'b0;
            nib     = word_nibble(lat_f2, 3'(pos - 6'd17));
        end else begin
            case (rpos) inside
                [6'd1:6'd4]: begin
                    lit_sel = 1'b0;
                    nib_bcd = 1'b1;
                    nib     = lat_time[{2'(6'd4 - rpos), 2'b00} +: 4];
                end
                6'd5:          lit_char = ASCII_AT;
                [6'd6:6'd13]: begin
                    lit_sel = 1'b0;
                    nib     = word_nibble(lat_pc, 3'(rpos - 6'd6));
                end
                6'd14:         lit_char = ASCII_COLON;
                6'd16:         lit_char = lat_mem ? ASCII_STAR : ASCII_DOLLAR;
                6'd17: begin
                    lit_sel = 1'b0;
                    nib     = num_tens;
                end
                6'd18: begin
                    lit_sel = 1'b0;
                    nib     = num_ones;
                end
                6'd20:         lit_char = ASCII_LT;
                6'd21:         lit_char = ASCII_EQ;
                [6'd23:6'd30]: begin
                    lit_sel = 1'b0;
                    nib     = word_nibble(lat_data, 3'(rpos - 6'd23));
                end
                6'd31:         lit_char = ASCII_HASH;
                default:       lit_char = ASCII_SP;
            endcase
        end
    end

    trace_hex_char u_hex (
        .nibble (nib),
        .bcd    (nib_bcd),
        .ascii  (hex_ascii)
    );

    assign nxt_char = lit_sel ? lit_char : hex_ascii;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            idx          <= 6'd0;
            char         <= ASCII_SP;
            reg_ack      <= 1'b0;
            mem_ack      <= 1'b0;
            busy         <= 1'b0;
            err_flag     <= 1'b0;
            err_cnt      <= '0;
            rr_mem_first <= 1'b0;
            lat_mem      <= 1'b0;
            lat_time     <= 16'd0;
            lat_pc       <= 32'd0;
            lat_f2       <= 32'd0;
            lat_data     <= 32'd0;
        end else begin
            reg_ack <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                S_EMIT: begin
                    if (idx == last_idx) begin
                        state <= S_CHECK;
                        char  <= ASCII_SP;
                        busy  <= 1'b0;
                    end else begin
                        idx  <= idx + 6'd1;
                        char <= nxt_char;
                    end
                end
                default: begin
                    // verdict refers to the line just finished, even if a new grant lands this edge
                    if (state == S_CHECK && CHECK_EN != 0 && format_type != exp_fmt) begin
                        err_flag <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                    if (grant_reg || grant_mem) begin
                        state        <= S_EMIT;
                        idx          <= 6'd0;
                        char         <= ASCII_CARET;
                        busy         <= 1'b1;
                        reg_ack      <= grant_reg;
                        mem_ack      <= grant_mem;
                        rr_mem_first <= grant_reg;
                        lat_mem      <= grant_mem;
                        lat_time     <= grant_mem ? mem_time : reg_time;
                        lat_pc       <= grant_mem ? mem_pc : reg_pc;
                        lat_f2       <= grant_mem ? mem_addr : {27'd0, reg_num};
                        lat_data     <= grant_mem ? mem_data : reg_data;
                    end else begin
                        state <= S_IDLE;
                        char  <= ASCII_SP;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_emitter.sv
// Bench for trace_emitter: vector table plus directed arbitration, error-count and reset sequences.
module tb_trace_emitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_req = 1'b0;
    logic [15:0] reg_time = 16'd0;
    logic [31:0] reg_pc = 32'd0;
    logic [4:0]  reg_num = 5'd0;
    logic [31:0] reg_data = 32'd0;
    logic        reg_ack;
    logic        mem_req = 1'b0;
    logic [15:0] mem_time = 16'd0;
    logic [31:0] mem_pc = 32'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_data = 32'd0;
    logic        mem_ack;
    logic [7:0]  char;
    logic [1:0]  format_type = 2'b00;
    logic        busy;
    logic        err_flag;
    logic [7:0]  err_cnt;

    int    total = 0;
    int    bad = 0;
    string exp_q[$];
    int    gap_q[$];
    int    force_sel = 0;
    bit    in_line = 1'b0;

    always #5 clk = ~clk;

    trace_emitter #(.ERR_W(8), .CHECK_EN(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_req     (reg_req),
        .reg_time    (reg_time),
        .reg_pc      (reg_pc),
        .reg_num     (reg_num),
        .reg_data    (reg_data),
        .reg_ack     (reg_ack),
        .mem_req     (mem_req),
        .mem_time    (mem_time),
        .mem_pc      (mem_pc),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .char        (char),
        .format_type (format_type),
        .busy        (busy),
        .err_flag    (err_flag),
        .err_cnt     (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, act, req);
        end
    endtask

    function automatic string bcd4(input logic [15:0] t);
        string s = "";
        for (int i = 3; i >= 0; i--) s = {s, $sformatf("%c", 8'h30 + 8'(t[i*4 +: 4]))};
        return s;
    endfunction

    function automatic string hx8(input logic [31:0] v);
        string d = "0123456789abcdef";
        string s = "";
        for (int i = 7; i >= 0; i--) s = {s, $sformatf("%c", d.getc(int'(v[i*4 +: 4])))};
        return s;
    endfunction

    function automatic string reg_line(input logic [15:0] t, input logic [31:0] pc,
                                       input int n, input logic [31:0] d);
        return {"^", bcd4(t), "@", hx8(pc), ": $",
                $sformatf("%c%c", 8'(48 + n / 10), 8'(48 + n % 10)), " <= ", hx8(d), "#"};
    endfunction

    function automatic string mem_line(input logic [15:0] t, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] d);
        return {"^", bcd4(t), "@", hx8(pc), ": *", hx8(a), " <= ", hx8(d), "#"};
    endfunction

    // Line collector: assembles chars while busy, drives the verdict, checks against the scoreboard.
    initial begin
        string got;
        string hd;
        bit    ack_bad;
        bit    exp_mem;
        int    idle_run;
        got = "";
        ack_bad = 1'b0;
        idle_run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_line = 1'b0;
                idle_run = 0;
            end else if (busy) begin
                if (!in_line) begin
                    in_line = 1'b1;
                    got = "";
                    ack_bad = 1'b0;
                    gap_q.push_back(idle_run);
                    idle_run = 0;
                    exp_mem = 1'b0;
                    if (exp_q.size() > 0) begin
                        hd = exp_q[0];
                        exp_mem = (hd.getc(16) == 8'h2a);
                    end
                    case (force_sel)
                        1:       format_type = 2'b00;
                        2:       format_type = exp_mem ? 2'b01 : 2'b10;
                        default: format_type = exp_mem ? 2'b10 : 2'b01;
                    endcase
                end else if (reg_ack || mem_ack) begin
                    ack_bad = 1'b1;
                end
                got = {got, $sformatf("%c", char)};
            end else begin
                idle_run++;
                if (in_line) begin
                    in_line = 1'b0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_line: got \"%s\" want none", got);
                    end else begin
                        hd = exp_q.pop_front();
                        chk_str("line", got, hd);
                    end
                    chk("separator_char", char, 8'h20);
                    chk("ack_during_emit", ack_bad, 0);
                end
            end
        end
    end

    task automatic wait_ack(input bit mem);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (mem ? mem_ack : reg_ack) seen = 1'b1;
        end
        if (seen) begin
            chk(mem ? "mem_ack_first_char" : "reg_ack_first_char", char, 8'h5e);
            chk("ack_busy", busy, 1);
        end else begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack in %0d cycles want ack (mem=%0d)", n, mem);
        end
        if (mem) mem_req = 1'b0;
        else reg_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy || in_line) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got %0d lines pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_reg(input logic [15:0] t, input logic [31:0] pc, input logic [4:0] n,
                           input logic [31:0] d);
        reg_time = t;
        reg_pc = pc;
        reg_num = n;
        reg_data = d;
        reg_req = 1'b1;
    endtask

    task automatic set_mem(input logic [15:0] t, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] d);
        mem_time = t;
        mem_pc = pc;
        mem_addr = a;
        mem_data = d;
        mem_req = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        bit          is_mem;
        logic [15:0] t;
        logic [31:0] pc;
        logic [31:0] f2;
        logic [31:0] d;
    } vec_t;

    vec_t  vt[6];
    string vs[6];

    initial begin
        vt[0] = '{1'b0, 16'h0012, 32'h00003000, 32'd5,        32'h0000abcd};
        vs[0] = "^0012@00003000: $05 <= 0000abcd#";
        vt[1] = '{1'b1, 16'h0007, 32'h00003004, 32'h00000010, 32'hffffffff};
        vs[1] = "^0007@00003004: *00000010 <= ffffffff#";
        vt[2] = '{1'b0, 16'h9999, 32'hdeadbeef, 32'd31,       32'h12345678};
        vs[2] = "^9999@deadbeef: $31 <= 12345678#";
        vt[3] = '{1'b0, 16'h0000, 32'h00000000, 32'd0,        32'h00000000};
        vs[3] = "^0000@00000000: $00 <= 00000000#";
        vt[4] = '{1'b1, 16'h1a2f, 32'h89abcdef, 32'hcafef00d, 32'h00000001};
        vs[4] = "^1:2?@89abcdef: *cafef00d <= 00000001#";
        vt[5] = '{1'b0, 16'h2024, 32'hfedcba98, 32'd19,       32'h0badf00d};
        vs[5] = "^2024@fedcba98: $19 <= 0badf00d#";

        repeat (3) @(negedge clk);
        chk("rst_char", char, 8'h20);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {reg_ack, mem_ack}, 0);
        chk("rst_err", {err_flag, err_cnt}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_char", char, 8'h20);

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vs[i]);
            if (vt[i].is_mem) begin
                set_mem(vt[i].t, vt[i].pc, vt[i].f2, vt[i].d);
                wait_ack(1'b1);
            end else begin
                set_reg(vt[i].t, vt[i].pc, vt[i].f2[4:0], vt[i].d);
                wait_ack(1'b0);
            end
            wait_idle();
            chk($sformatf("err_after_vec%0d", i), {err_flag, err_cnt}, 0);
        end

        // Simultaneous requests after reset: reg first; reg re-requests while mem waits -> mem next.
        pulse_reset();
        exp_q.push_back(reg_line(16'h0101, 32'h00000100, 1, 32'h11111111));
        exp_q.push_back(mem_line(16'h0202, 32'h00000200, 32'h00002222, 32'h22222222));
        exp_q.push_back(reg_line(16'h0303, 32'h00000300, 3, 32'h33333333));
        gap_q.delete();
        set_reg(16'h0101, 32'h00000100, 5'd1, 32'h11111111);
        set_mem(16'h0202, 32'h00000200, 32'h00002222, 32'h22222222);
        wait_ack(1'b0);
        chk("rr_mem_not_acked", mem_ack, 0);
        set_reg(16'h0303, 32'h00000300, 5'd3, 32'h33333333);
        wait_ack(1'b1);
        chk("rr_reg_not_acked", reg_ack, 0);
        wait_ack(1'b0);
        wait_idle();
        chk("rr_line_count", gap_q.size(), 3);
        chk("rr_gap_b", (gap_q.size() > 1) ? gap_q[1] : -1, 1);
        chk("rr_gap_c", (gap_q.size() > 2) ? gap_q[2] : -1, 1);
        chk("rr_no_err", {err_flag, err_cnt}, 0);

        // Wrong verdicts: one swapped, then 299 absent; counter saturates.
        force_sel = 2;
        exp_q.push_back(reg_line(16'h0042, 32'h0000abc0, 7, 32'h0000beef));
        set_reg(16'h0042, 32'h0000abc0, 5'd7, 32'h0000beef);
        wait_ack(1'b0);
        wait_idle();
        chk("err_swapped_cnt", err_cnt, 1);
        chk("err_swapped_flag", err_flag, 1);
        force_sel = 1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(reg_line(16'h0042, 32'h0000abc0, 7, 32'h0000beef));
            set_reg(16'h0042, 32'h0000abc0, 5'd7, 32'h0000beef);
            wait_ack(1'b0);
        end
        wait_idle();
        chk("err_cnt_3", err_cnt, 3);
        for (int k = 0; k < 297; k++) begin
            exp_q.push_back(reg_line(16'h0042, 32'h0000abc0, 7, 32'h0000beef));
            set_reg(16'h0042, 32'h0000abc0, 5'd7, 32'h0000beef);
            wait_ack(1'b0);
        end
        wait_idle();
        chk("err_cnt_sat", err_cnt, 255);
        chk("err_flag_sat", err_flag, 1);
        force_sel = 0;

        // Reset at char index 10 abandons the line.
        set_reg(16'h5555, 32'h55555555, 5'd5, 32'h55555555);
        wait_ack(1'b0);
        repeat (10) @(negedge clk);
        chk("mid_line_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_char", char, 8'h20);
        chk("abort_busy", busy, 0);
        chk("abort_err_cnt", err_cnt, 0);
        chk("abort_err_flag", err_flag, 0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", k), {busy, char}, {1'b0, 8'h20});
        end

        // Pointer back to reg after reset, fresh line starts from '^'.
        exp_q.push_back(reg_line(16'h0606, 32'h00000600, 0, 32'h66666666));
        exp_q.push_back(mem_line(16'h0707, 32'h00000700, 32'h00007777, 32'h77777777));
        set_reg(16'h0606, 32'h00000600, 5'd0, 32'h66666666);
        set_mem(16'h0707, 32'h00000700, 32'h00007777, 32'h77777777);
        wait_ack(1'b0);
        wait_ack(1'b1);
        wait_idle();
        chk("final_no_err", {err_flag, err_cnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_emitter.md
TRACE_EMITTER -- requirements
Module: trace_emitter

Interface
REQ-001 Parameter ERR_W, default 8, width of the saturating format-error counter.
REQ-002 Parameter CHECK_EN, default 1; 1 = compare checker verdict after each line, 0 = err_cnt/err_flag held 0.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 reg_req  input  1  register-write trace request; held with fields until reg_ack.
REQ-006 reg_time  input  16  four BCD digits, most significant first.
REQ-007 reg_pc  input  32  PC.
REQ-008 reg_num  input  5  GRF index 0..31.
REQ-009 reg_data  input  32  written value.
REQ-010 reg_ack  output  1  one-cycle pulse; fields captured this edge.
REQ-011 mem_req, mem_time[16], mem_pc[32], mem_addr[32], mem_data[32], mem_ack  same roles for memory-write traces.
REQ-012 char  output  8  ASCII character to the format checker, one per cycle.
REQ-013 format_type  input  2  checker verdict (01 reg line, 10 mem line, 00 none).
REQ-014 busy  output  1  high while a line is being emitted.
REQ-015 err_flag  output  1  sticky, set on any verdict mismatch.
REQ-016 err_cnt  output  ERR_W  mismatch count, saturates at all-ones.

Function
REQ-017 FSM states SHALL be IDLE, EMIT, CHECK; IDLE and CHECK drive char = 0x20 (space).
REQ-018 Grant SHALL occur only in IDLE or CHECK when either req is high; ack pulses that edge, fields latched, FSM -> EMIT with index 0.
REQ-019 Arbitration SHALL be round-robin: with both requesting, grant the channel not granted last; after reset reg wins first.
REQ-020 Reg line SHALL be exactly 32 chars: "^" tttt "@" pppppppp ": $" nn " <= " dddddddd "#".
REQ-021 Mem line SHALL be exactly 38 chars: "^" tttt "@" pppppppp ": *" aaaaaaaa " <= " dddddddd "#".
REQ-022 Time digits SHALL be the four BCD nibbles as "0".."9" with leading zeros; BCD nibbles >9 are emitted unchanged as nibble+0x30 (no correction).
REQ-023 nn SHALL be two decimal digits, 00..31, with a leading zero.
REQ-024 Hex fields SHALL be 8 lowercase digits, most significant nibble first.
REQ-025 EMIT SHALL advance one char per cycle with no gaps; after "#" FSM -> CHECK for exactly one cycle.
REQ-026 In CHECK with CHECK_EN=1, format_type SHALL equal 01 (reg) or 10 (mem); on mismatch err_flag <= 1 and err_cnt increments unless all-ones.
REQ-027 A new grant in CHECK SHALL be permitted, giving back-to-back lines with one separator cycle.
REQ-028 busy SHALL be 1 exactly in EMIT.
REQ-029 Requests arriving during EMIT SHALL wait; no ack until granted.

Reset
REQ-030 With reset=0 at a posedge: FSM -> IDLE, char = 0x20, acks 0, busy 0, err_flag 0, err_cnt 0, round-robin pointer -> reg.
REQ-031 Reset mid-line SHALL abandon the line with no CHECK and no further characters; the requester's transaction stays acked.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, line lengths (32/38), ASCII constants, and the verdict codes 01/10.
REQ-033 One sub-module, trace_hex_char (4-bit nibble -> lowercase ASCII), SHALL be used for all hex and BCD digits.

Verification
REQ-034 Reg req time=0x0012, pc=0x00003000, num=5, data=0x0000abcd -> "^0012@00003000: $05 <= 0000abcd#" over 32 cycles; format_type=01 in CHECK; err_cnt stays 0.
REQ-035 Mem req time=0x0007, pc=0x00003004, addr=0x00000010, data=0xffffffff -> 38-char line ending "*00000010 <= ffffffff#"; verdict 10 expected.
REQ-036 Both reqs high in the same cycle after reset -> reg line, one space, then mem line; repeat -> mem granted before reg.
REQ-037 Force format_type=00 in CHECK for 300 lines (ERR_W=8) -> err_flag=1, err_cnt saturates at 255.
REQ-038 reset=0 at char index 10 of a reg line -> next cycle char=0x20, busy=0, err_cnt=0; next req is emitted from "^".
REQ-039 reg_num=31 and reg_num=0 -> "$31" and "$00".
